tcp_segment_extractor: RTL
==========================

// Module: tcp_segment_extractor
// PURPOSE
//  Sits directly upstream of the TCP reorder buffer. Consumes one TCP segment per AXI-Stream
//  packet (TCP header + payload; IP already stripped), parses the header, strips it (20-60 B
//  incl. options) and emits the payload re-aligned to byte lane 0. Drives the per-segment
//  seq_start and, on SYN, the stream base (seq_base/base_valid) that the reorder buffer consumes.
// PARAMETERS
//  DATA_WIDTH  64  stream width in bits; multiple of 32; BYTES = DATA_WIDTH/8
//  SEQ_BITS    32  sequence number width
// PORTS
//  clk          in   1          single clock; all logic posedge
//  rst_n        in   1          synchronous, active-low reset
//  s_axis       axi_stream_if   slave; tdata/tkeep/tvalid/tready/tlast/tuser; byte i = tdata[8*i+:8]
//  m_axis       axi_stream_if   master; payload only, lane-0 aligned, tuser driven 0
//  seq_start    out  SEQ_BITS   seq number of first payload byte of the segment on m_axis
//  seq_base     out  SEQ_BITS   ISN+1, valid with base_valid
//  base_valid   out  1          1-cycle pulse when a SYN segment's header is parsed
//  drop_pulse   out  1          1-cycle pulse per segment discarded (runt/bad doff/filtered)
// BEHAVIOUR
//  Reset: m_axis.tvalid=0, tlast=0, tkeep=0, tdata=0, seq_start=0, seq_base=0, base_valid=0,
//   drop_pulse=0, state=HDR, residue empty. Reset mid-segment abandons it; next beat is a header.
//  Header fields big-endian in byte order: seq=B4..B7, doff=B12[7:4], flags=B13 (SYN=bit1).
//   hdr_len = doff*4. Header may span ceil(hdr_len/BYTES) beats.
//  FSM: HDR -> accumulate bytes until hdr_len reached. doff<5 or tlast before hdr_len -> DROP
//   (or straight to HDR if that beat carried tlast), drop_pulse=1.
//   Header done: latch seq_start=seq (+1 if SYN, mod 2^SEQ_BITS). If SYN: seq_base=seq+1,
//   base_valid=1 next cycle. If payload bytes remain -> PAYLOAD, else -> HDR (no output beat).
//  PAYLOAD: shift = hdr_len mod BYTES. Output beat = residue bytes + low bytes of next input
//   beat; leftover input bytes stored as residue. Input tlast whose bytes don't fit -> FLUSH.
//  FLUSH: emit residue with tlast=1, tkeep contiguous from bit 0; -> HDR.
//  DROP: tready=1, discard until tlast handshake; -> HDR.
//  Output: registered stage; m_axis.tlast only on final payload beat; tkeep always contiguous
//   from bit 0; never an output beat with tkeep==0. Payload of 1 byte -> tkeep=...0001.
//  Handshake: s_axis.tready=1 in HDR/DROP; in PAYLOAD tready = !m_axis.tvalid || m_axis.tready;
//   0 in FLUSH. m_axis beat held stable until tready. No combinational tready->tready path
//   except the above registered-slot formula.
//  seq_start: updated only at header completion and only when no payload beat of the previous
//   segment is pending on m_axis; held stable from first to last payload beat of a segment.
//   Header completion with output still occupied stalls s_axis (tready=0) until it drains.
//  Latency: first payload beat valid 1 cycle after the input beat supplying its last byte
//   (shift 0: 1 cycle after the first payload-carrying input beat). Full throughput in PAYLOAD.
//  base_valid and drop_pulse never asserted in the same cycle (SYN drop gives no base_valid).
// CONFIGURATION
//  TCP_PORT_FILTER_EN defined: adds input port cfg_dst_port[15:0]; segments whose dst port
//   (B2..B3) != cfg_dst_port -> DROP with drop_pulse, no seq_start update, no base_valid.
//  Not defined: port absent, all well-formed segments forwarded.
// STRUCTURE
//  tcp_parse_pkg: header byte offsets, TCP_FLAG_* bit constants, MIN_DOFF=5, state_t enum
//   {HDR,PAYLOAD,FLUSH,DROP}. Sub-module axis_byte_realigner (residue+shift, tkeep merge,
//   flush) instantiated once; FSM/header parse stays in top.
// TESTING  (DATA_WIDTH=64)
//  1. doff=5, seq=0x1000, 24 B payload -> 3 beats tkeep FF,FF,FF, tlast on 3rd, seq_start=0x1000.
//  2. doff=6 (24 B hdr, shift 0), 13 B payload -> beats FF,1F; doff=8 (32 B) also shift 0.
//  3. doff=5 (shift 4), 9 B payload -> realigned beats FF,01; bytes match; tlast on 2nd.
//  4. SYN seq=0xFFFFFFFF, no payload -> base_valid pulse, seq_base=0, no m_axis beat.
//  5. Runt (12 B, tlast) and doff=4 -> drop_pulse each, no output; next good segment passes.
//  6. Random m_axis.tready backpressure, 10 random segments 8-32 B -> byte-exact, seq_start
//   stable per segment; with TCP_PORT_FILTER_EN, mismatched port -> dropped.

Source files
------------

// File: rtl/tcp_parse_pkg.sv
// rtl/tcp_parse_pkg.sv - TCP header byte offsets, flag bits and parser state encoding
package tcp_parse_pkg;

   // Byte offsets within the TCP header (big-endian fields)
   localparam int TCP_OFF_DST_PORT = 2;
   localparam int TCP_OFF_SEQ      = 4;
   localparam int TCP_OFF_DOFF     = 12;
   localparam int TCP_OFF_FLAGS    = 13;
   // Header bytes the parser needs to see (B0..B13)
   localparam int TCP_HDR_CAPTURE  = 14;

   localparam int TCP_FLAG_FIN = 0;
   localparam int TCP_FLAG_SYN = 1;
   localparam int TCP_FLAG_RST = 2;
   localparam int TCP_FLAG_ACK = 4;

   localparam logic [3:0] MIN_DOFF = 4'd5;

   typedef enum logic [1:0] {
      HDR,
      PAYLOAD,
      FLUSH,
      DROP
   } state_t;

endpackage

// File: rtl/axis_byte_realigner.sv
// rtl/axis_byte_realigner.sv - merges a byte residue with shifted input bytes into lane-0 aligned output beats
module axis_byte_realigner #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push_i,
   input  logic                    flush_i,
   input  logic [DATA_WIDTH-1:0]   in_data_i,
   input  logic [7:0]              in_off_i,
   input  logic [7:0]              in_cnt_i,
   input  logic                    in_last_i,
   output logic                    ready_o,
   output logic                    need_flush_o,
   output logic [DATA_WIDTH-1:0]   m_tdata_o,
   output logic [DATA_WIDTH/8-1:0] m_tkeep_o,
   output logic                    m_tvalid_o,
   output logic                    m_tlast_o,
   input  logic                    m_tready_i
);
   localparam int BYTES = DATA_WIDTH / 8;

   function automatic logic [BYTES-1:0] keep_mask(input logic [7:0] n);
      for (int i = 0; i < BYTES; i++) keep_mask[i] = (8'(i) < n);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] bit_mask(input logic [BYTES-1:0] k);
      for (int i = 0; i < BYTES; i++) bit_mask[8*i +: 8] = {8{k[i]}};
   endfunction

   logic [DATA_WIDTH-1:0]   res_q, res_d;
   logic [7:0]              res_cnt_q, res_cnt_d;
   logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
   logic [BYTES-1:0]        out_keep_q, out_keep_d;
   logic                    out_valid_q, out_valid_d;
   logic                    out_last_q, out_last_d;

   logic [DATA_WIDTH-1:0]   shifted;
   logic [2*DATA_WIDTH-1:0] wide;
   logic [7:0]              total;

   // Residue/output-slot next state: residue bytes first, then the new input bytes behind them
   always_comb begin
      res_d        = res_q;
      res_cnt_d    = res_cnt_q;
      out_data_d   = out_data_q;
      out_keep_d   = out_keep_q;
      out_last_d   = out_last_q;
      out_valid_d  = out_valid_q;
      ready_o      = !out_valid_q || m_tready_i;
      shifted      = (in_data_i >> {in_off_i, 3'b000}) & bit_mask(keep_mask(in_cnt_i));
      wide         = {{DATA_WIDTH{1'b0}}, res_q} | ({{DATA_WIDTH{1'b0}}, shifted} << {res_cnt_q, 3'b000});
      total        = res_cnt_q + in_cnt_i;
      need_flush_o = push_i && in_last_i && (total > 8'(BYTES));

      if (out_valid_q && m_tready_i) out_valid_d = 1'b0;

      if (flush_i) begin
         out_valid_d = 1'b1;
         out_data_d  = res_q;
         out_keep_d  = keep_mask(res_cnt_q);
         out_last_d  = 1'b1;
         res_d       = '0;
         res_cnt_d   = '0;
      end else if (push_i) begin
         if (total >= 8'(BYTES)) begin
            out_valid_d = 1'b1;
            out_data_d  = wide[DATA_WIDTH-1:0];
            out_keep_d  = '1;
            out_last_d  = in_last_i && (total == 8'(BYTES));
            res_d       = wide[2*DATA_WIDTH-1:DATA_WIDTH];
            res_cnt_d   = total - 8'(BYTES);
         end else if (in_last_i) begin
            out_valid_d = 1'b1;
            out_data_d  = wide[DATA_WIDTH-1:0];
            out_keep_d  = keep_mask(total);
            out_last_d  = 1'b1;
            res_d       = '0;
            res_cnt_d   = '0;
         end else begin
            res_d       = wide[DATA_WIDTH-1:0];
            res_cnt_d   = total;
         end
      end
   end

   // Residue and registered output slot
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_q       <= '0;
         res_cnt_q   <= '0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         res_q       <= res_d;
         res_cnt_q   <= res_cnt_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   assign m_tdata_o  = out_data_q;
   assign m_tkeep_o  = out_keep_q;
   assign m_tvalid_o = out_valid_q;
   assign m_tlast_o  = out_last_q;

endmodule

// File: rtl/tcp_segment_extractor.sv
// rtl/tcp_segment_extractor.sv - parses/strips TCP headers, emits lane-0 aligned payload; optional TCP_PORT_FILTER_EN adds dst-port filtering
module tcp_segment_extractor
   import tcp_parse_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int SEQ_BITS   = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata_i,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep_i,
   input  logic                    s_axis_tvalid_i,
   input  logic                    s_axis_tlast_i,
   input  logic                    s_axis_tuser_i,
   output logic                    s_axis_tready_o,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata_o,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep_o,
   output logic                    m_axis_tvalid_o,
   output logic                    m_axis_tlast_o,
   output logic                    m_axis_tuser_o,
   input  logic                    m_axis_tready_i,
   output logic [SEQ_BITS-1:0]     seq_start_o,
   output logic [SEQ_BITS-1:0]     seq_base_o,
   output logic                    base_valid_o,
   output logic                    drop_pulse_o
`ifdef TCP_PORT_FILTER_EN
   ,
   input  logic [15:0]             cfg_dst_port_i
`endif
);
   localparam int BYTES = DATA_WIDTH / 8;

   function automatic logic [7:0] count_keep(input logic [BYTES-1:0] k);
      count_keep = '0;
      for (int i = 0; i < BYTES; i++) count_keep = count_keep + 8'(k[i]);
   endfunction

   function automatic logic [7:0] byte_at(input logic [DATA_WIDTH-1:0] d, input logic [7:0] lane);
      logic [DATA_WIDTH-1:0] t;
      t       = d >> {lane, 3'b000};
      byte_at = t[7:0];
   endfunction

   state_t              state_q, state_d;
   logic [7:0]          hdr_cnt_q, hdr_cnt_d;
   logic [7:0]          hdr_q [TCP_HDR_CAPTURE];
   logic [7:0]          hdr_d [TCP_HDR_CAPTURE];
   logic [SEQ_BITS-1:0] seq_start_q, seq_start_d;
   logic [SEQ_BITS-1:0] seq_base_q, seq_base_d;
   logic                base_valid_q, base_valid_d;
   logic                drop_q, drop_d;

   logic [7:0]          hdr_v [TCP_HDR_CAPTURE];
   logic [7:0]          nbytes, bytes_total, hdr_len, pay_cnt, pay_off;
   logic [3:0]          doff;
   logic                doff_known, bad_doff, hdr_done, syn_v, port_ok, beat;
   logic [SEQ_BITS-1:0] seq_v;

   logic                rl_push, rl_flush, rl_ready, rl_need_flush;
   logic [7:0]          rl_off, rl_cnt;

   // Header view: bytes arriving on this beat override what earlier beats captured
   always_comb begin
      nbytes      = count_keep(s_axis_tkeep_i);
      bytes_total = hdr_cnt_q + nbytes;
      for (int k = 0; k < TCP_HDR_CAPTURE; k++) begin
         if ((8'(k) >= hdr_cnt_q) && (8'(k) < bytes_total))
            hdr_v[k] = byte_at(s_axis_tdata_i, 8'(k) - hdr_cnt_q);
         else
            hdr_v[k] = hdr_q[k];
      end
   end

   assign doff       = hdr_v[TCP_OFF_DOFF][7:4];
   assign doff_known = bytes_total > 8'(TCP_OFF_DOFF);
   assign hdr_len    = {2'b00, doff, 2'b00};
   assign bad_doff   = doff_known && (doff < MIN_DOFF);
   assign hdr_done   = doff_known && !bad_doff && (bytes_total >= hdr_len);
   assign pay_cnt    = bytes_total - hdr_len;
   assign pay_off    = hdr_len - hdr_cnt_q;
   assign syn_v      = hdr_v[TCP_OFF_FLAGS][TCP_FLAG_SYN];
   assign seq_v      = SEQ_BITS'({hdr_v[TCP_OFF_SEQ], hdr_v[TCP_OFF_SEQ+1],
                                  hdr_v[TCP_OFF_SEQ+2], hdr_v[TCP_OFF_SEQ+3]});

`ifdef TCP_PORT_FILTER_EN
   assign port_ok = ({hdr_v[TCP_OFF_DST_PORT], hdr_v[TCP_OFF_DST_PORT+1]} == cfg_dst_port_i);
   logic unused_hdr;
   assign unused_hdr = ^{hdr_v[0], hdr_v[1], hdr_v[8], hdr_v[9], hdr_v[10], hdr_v[11],
                         hdr_v[12][3:0], hdr_v[13], s_axis_tuser_i};
`else
   assign port_ok = 1'b1;
   logic unused_hdr;
   assign unused_hdr = ^{hdr_v[0], hdr_v[1], hdr_v[2], hdr_v[3], hdr_v[8], hdr_v[9],
                         hdr_v[10], hdr_v[11], hdr_v[12][3:0], hdr_v[13], s_axis_tuser_i};
`endif

   // Parser FSM: input handshake, header completion, routing of payload bytes to the realigner
   always_comb begin
      state_d         = state_q;
      hdr_cnt_d       = hdr_cnt_q;
      hdr_d           = hdr_q;
      seq_start_d     = seq_start_q;
      seq_base_d      = seq_base_q;
      base_valid_d    = 1'b0;
      drop_d          = 1'b0;
      rl_push         = 1'b0;
      rl_flush        = 1'b0;
      rl_off          = '0;
      rl_cnt          = nbytes;
      s_axis_tready_o = 1'b0;

      unique case (state_q)
         HDR:     s_axis_tready_o = !(hdr_done && m_axis_tvalid_o);
         PAYLOAD: s_axis_tready_o = rl_ready;
         FLUSH:   s_axis_tready_o = 1'b0;
         DROP:    s_axis_tready_o = 1'b1;
         default: s_axis_tready_o = 1'b0;
      endcase
      beat = s_axis_tvalid_i && s_axis_tready_o;

      unique case (state_q)
         HDR: if (beat) begin
            hdr_d = hdr_v;
            if (bad_doff || (hdr_done && !port_ok)) begin
               drop_d    = 1'b1;
               hdr_cnt_d = '0;
               state_d   = s_axis_tlast_i ? HDR : DROP;
            end else if (hdr_done) begin
               hdr_cnt_d   = '0;
               seq_start_d = seq_v + SEQ_BITS'(syn_v);
               if (syn_v) begin
                  base_valid_d = 1'b1;
                  seq_base_d   = seq_v + SEQ_BITS'(1);
               end
               if (pay_cnt != 8'd0) begin
                  rl_push = 1'b1;
                  rl_off  = pay_off;
                  rl_cnt  = pay_cnt;
               end
               if (s_axis_tlast_i) state_d = rl_need_flush ? FLUSH : HDR;
               else                state_d = PAYLOAD;
            end else if (s_axis_tlast_i) begin
               drop_d    = 1'b1;
               hdr_cnt_d = '0;
            end else begin
               hdr_cnt_d = bytes_total;
            end
         end
         PAYLOAD: if (beat) begin
            rl_push = 1'b1;
            if (s_axis_tlast_i) state_d = rl_need_flush ? FLUSH : HDR;
         end
         FLUSH: if (rl_ready) begin
            rl_flush = 1'b1;
            state_d  = HDR;
         end
         DROP: if (beat && s_axis_tlast_i) state_d = HDR;
         default: state_d = HDR;
      endcase
   end

   // Parser state, captured header bytes and per-segment sequence outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= HDR;
         hdr_cnt_q    <= '0;
         for (int k = 0; k < TCP_HDR_CAPTURE; k++) hdr_q[k] <= '0;
         seq_start_q  <= '0;
         seq_base_q   <= '0;
         base_valid_q <= 1'b0;
         drop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         hdr_cnt_q    <= hdr_cnt_d;
         hdr_q        <= hdr_d;
         seq_start_q  <= seq_start_d;
         seq_base_q   <= seq_base_d;
         base_valid_q <= base_valid_d;
         drop_q       <= drop_d;
      end
   end

   axis_byte_realigner #(.DATA_WIDTH(DATA_WIDTH)) u_realign (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (rl_push),
      .flush_i      (rl_flush),
      .in_data_i    (s_axis_tdata_i),
      .in_off_i     (rl_off),
      .in_cnt_i     (rl_cnt),
      .in_last_i    (s_axis_tlast_i),
      .ready_o      (rl_ready),
      .need_flush_o (rl_need_flush),
      .m_tdata_o    (m_axis_tdata_o),
      .m_tkeep_o    (m_axis_tkeep_o),
      .m_tvalid_o   (m_axis_tvalid_o),
      .m_tlast_o    (m_axis_tlast_o),
      .m_tready_i   (m_axis_tready_i)
   );

   assign m_axis_tuser_o = 1'b0;
   assign seq_start_o    = seq_start_q;
   assign seq_base_o     = seq_base_q;
   assign base_valid_o   = base_valid_q;
   assign drop_pulse_o   = drop_q;

endmodule
